// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and reader FSM encoding.
package seg7_pkg;

  // Active-low a..g pattern, index 0 = a
  typedef logic [0:6] seg_t;

  typedef struct packed {
    seg_t tens;
    seg_t ones;
  } seg_pair_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_pair_t PAIR_BLANK = '{tens: SEG_BLANK, ones: SEG_BLANK};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_VALID  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pair_reader_if.sv
// Segment inputs plus valid/ready result channel of the pair reader.
interface seg7_pair_reader_if
  import seg7_pkg::*;
  ();

  seg_t        seg_tens;
  seg_t        seg_ones;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_value;
  logic        out_err;

  // Stimulus / consumer side
  modport master (
    output seg_tens, seg_ones, out_ready,
    input  out_valid, out_value, out_err
  );

  // Reader side
  modport slave (
    input  seg_tens, seg_ones, out_ready,
    output out_valid, out_value, out_err
  );

endinterface

// File: rtl/seg7_digit_decode.sv
// Maps one active-low segment pattern back to its digit, flagging blank and illegal.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  seg_t       seg,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_blank
);

  // Pattern lookup; anything not in the table is neither digit nor blank
  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    is_blank = 1'b0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_pair_reader.sv
// Debounces a tens/ones segment pair and reports its 0..15 value once per change.
module seg7_pair_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  seg7_pair_reader_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  seg_pair_t        din;
  seg_pair_t        samp;
  seg_pair_t        last_rep;
  seg_pair_t        rep_pat;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic             clr_cnt_c;

  logic             t_dig, t_blank, o_dig, o_blank;
  logic [3:0]       t_digit, o_digit;
  logic             dec_err;
  logic [3:0]       dec_value;

  assign din = '{tens: bus.seg_tens, ones: bus.seg_ones};

  // Accepting a report while the display has already moved on restarts settling
  assign clr_cnt_c = (state == ST_VALID) && bus.out_ready && (samp != rep_pat);

  // Input sample register and saturating stability counter
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      samp <= PAIR_BLANK;
      cnt  <= '0;
    end else begin
      samp <= din;
      if (din != samp || clr_cnt_c)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  seg7_digit_decode u_dec_tens (
    .seg      (samp.tens),
    .is_digit (t_dig),
    .digit    (t_digit),
    .is_blank (t_blank)
  );

  seg7_digit_decode u_dec_ones (
    .seg      (samp.ones),
    .is_digit (o_dig),
    .digit    (o_digit),
    .is_blank (o_blank)
  );

  // Pair rules: blank+digit is 0..9, "1"+0..5 is 10..15, all else illegal
  always_comb begin
    dec_err   = 1'b1;
    dec_value = 4'd0;
    if (t_blank && o_dig) begin
      dec_err   = 1'b0;
      dec_value = o_digit;
    end else if (t_dig && (t_digit == 4'd1) && o_dig && (o_digit <= 4'd5)) begin
      dec_err   = 1'b0;
      dec_value = 4'd10 + o_digit;
    end
  end

  // Report FSM with registered handshake outputs
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.out_valid <= 1'b0;
      bus.out_value <= 4'd0;
      bus.out_err   <= 1'b0;
      last_rep      <= PAIR_BLANK;
      rep_pat       <= PAIR_BLANK;
    end else begin
      case (state)
        ST_IDLE: begin
          // A non-saturated counter means the sample moved since it last settled
          if (cnt != CNT_MAX)
            state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == CNT_MAX) begin
            if (samp == last_rep || samp == PAIR_BLANK) begin
              state <= ST_IDLE;
            end else begin
              state         <= ST_VALID;
              bus.out_valid <= 1'b1;
              bus.out_value <= dec_value;
              bus.out_err   <= dec_err;
              rep_pat       <= samp;
            end
          end
        end
        ST_VALID: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            last_rep      <= rep_pat;
            state         <= (samp != rep_pat) ? ST_SETTLE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
